// File: rtl/cache_regfile.sv
// cache_regfile: DEPTH x WIDTH register-file cache with one write port, two
// registered read ports, per-entry valid bits and a one-entry-per-cycle clear
// sweep. Reads see same-edge writes and hide the entry being swept this cycle.

// One registered read port; instantiated once per read port by the top.
module cache_regfile_rd_port #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
    input  logic [DEPTH-1:0]             valid,
    input  logic                         busy,
    input  logic [ADDR_W-1:0]            ptr,
    input  logic                         wr_ok,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [ADDR_W-1:0]            addr,
    output logic [WIDTH-1:0]             data,
    output logic                         vld
);
    logic             in_range;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_vld;

    assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));

    // Next read value: the swept entry reads as cleared, then a same-edge
    // write wins over stored contents; out-of-range addresses read 0/invalid.
    // A write is never accepted while busy, so the first two cannot collide.
    always_comb begin
        nxt_data = '0;
        nxt_vld  = 1'b0;
        if (busy && addr == ptr) begin
            nxt_data = '0;
            nxt_vld  = 1'b0;
        end else if (wr_ok && addr == wr_addr) begin
            nxt_data = wr_data;
            nxt_vld  = 1'b1;
        end else if (in_range) begin
            nxt_data = mem[addr];
            nxt_vld  = valid[addr];
        end
    end

    // Output register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            vld  <= 1'b0;
        end else begin
            data <= nxt_data;
            vld  <= nxt_vld;
        end
    end
endmodule

module cache_regfile #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b,
    input  logic              clr_req,
    output logic              busy
);
    localparam int NUM_RD = 2;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t                        state;
    logic [ADDR_W-1:0]             ptr;
    logic [DEPTH-1:0][WIDTH-1:0]   mem;
    logic [DEPTH-1:0]              valid;
    logic                          wr_ok;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
    logic [NUM_RD-1:0]             rd_vld;

    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < (ADDR_W+1)'(DEPTH));

    // Storage, valid bits and clear sequencer; busy is a registered FSM output
    // that is high for exactly the DEPTH cycles spent in SWEEP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            mem   <= '0;
            valid <= '0;
        end else begin
            if (wr_ok) begin
                mem[wr_addr]   <= wr_data;
                valid[wr_addr] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    mem[ptr]   <= '0;
                    valid[ptr] <= 1'b0;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        cache_regfile_rd_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W)
        ) u_rd (
            .clk    (clk),
            .rst_n  (rst_n),
            .mem    (mem),
            .valid  (valid),
            .busy   (busy),
            .ptr    (ptr),
            .wr_ok  (wr_ok),
            .wr_addr(wr_addr),
            .wr_data(wr_data),
            .addr   (rd_addr[p]),
            .data   (rd_data[p]),
            .vld    (rd_vld[p])
        );
    end

    assign rd_data_a  = rd_data[0];
    assign rd_valid_a = rd_vld[0];
    assign rd_data_b  = rd_data[1];
    assign rd_valid_b = rd_vld[1];
endmodule

// File: tb/tb_cache_regfile.sv
// Scoreboard bench for cache_regfile: an 8-entry and a 5-entry instance share
// the clock and reset. Stimulus pushes expected outputs tagged with the cycle
// they must appear in; a monitor pops and compares on every falling edge.
module tb_cache_regfile;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8-entry instance
    logic        wr_en, clr_req, busy;
    logic [2:0]  wr_addr, rd_addr_a, rd_addr_b;
    logic [15:0] wr_data, rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;

    // 5-entry instance
    logic        wr_en5, clr_req5, busy5;
    logic [2:0]  wr_addr5, rd_addr_a5, rd_addr_b5;
    logic [15:0] wr_data5, rd_data_a5, rd_data_b5;
    logic        rd_valid_a5, rd_valid_b5;

    cache_regfile #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
        .clr_req(clr_req), .busy(busy));

    cache_regfile #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .rd_addr_a(rd_addr_a5), .rd_data_a(rd_data_a5), .rd_valid_a(rd_valid_a5),
        .rd_addr_b(rd_addr_b5), .rd_data_b(rd_data_b5), .rd_valid_b(rd_valid_b5),
        .clr_req(clr_req5), .busy(busy5));

    typedef struct {
        string       name;
        int          due;
        int          sel;   // 0:A8 1:B8 2:busy8 3:A5 4:B5 5:busy5
        logic [15:0] d;
        logic        v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            logic [15:0] ad;
            logic        av;
            e = q.pop_front();
            case (e.sel)
                0: begin ad = rd_data_a;  av = rd_valid_a;  end
                1: begin ad = rd_data_b;  av = rd_valid_b;  end
                2: begin ad = 16'h0;      av = busy;        end
                3: begin ad = rd_data_a5; av = rd_valid_a5; end
                4: begin ad = rd_data_b5; av = rd_valid_b5; end
                default: begin ad = 16'h0; av = busy5; end
            endcase
            checks++;
            if (e.due != cyc || ad !== e.d || av !== e.v) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d got data=%h v=%b want data=%h v=%b",
                         e.name, cyc, e.due, ad, av, e.d, e.v);
            end
        end
    end

    // Expectation for the cycle after the current falling edge.
    task automatic exp(input int sel, input logic [15:0] d, input logic v, input string nm);
        exp_t e;
        e.name = nm; e.due = cyc + 1; e.sel = sel; e.d = d; e.v = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 0; clr_req = 0;
        wr_en5 = 0; wr_addr5 = 0; wr_data5 = 0; rd_addr_a5 = 0; rd_addr_b5 = 0; clr_req5 = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick(); tick();

        // 1: reset state, then every address reads 0/invalid
        exp(0, 16'h0, 0, "rst_a"); exp(1, 16'h0, 0, "rst_b"); exp(2, 16'h0, 0, "rst_busy");
        tick();
        rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            exp(0, 16'h0, 0, "t1_a"); exp(1, 16'h0, 0, "t1_b"); exp(2, 16'h0, 0, "t1_busy");
            tick();
        end

        // 2: write i*3, read A=i, B=7-i
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = 16'(i * 3);
            tick();
        end
        wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            exp(0, 16'(i * 3), 1, "t2_a"); exp(1, 16'((7 - i) * 3), 1, "t2_b");
            tick();
        end

        // 3: write-first bypass on both ports (addr 5 held 15 before)
        wr_en = 1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        exp(0, 16'hBEEF, 1, "t3_byp_a"); exp(1, 16'hBEEF, 1, "t3_byp_b");
        tick();
        wr_en = 0;
        exp(0, 16'hBEEF, 1, "t3_store_a");
        tick();

        // 4: fill, sweep, dropped write, ignored re-request, clear bypass
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = 16'h0100 + 16'(i);
            tick();
        end
        wr_en = 0;
        clr_req = 1;
        exp(2, 16'h0, 1, "t4_busy_start");
        tick();
        clr_req = 0;
        for (int k = 0; k < 8; k++) begin
            // ptr == k while these addresses are sampled
            rd_addr_a = 3'(k); rd_addr_b = 3'd7;
            wr_en   = (k == 2);
            wr_addr = 3'd7; wr_data = 16'h1234;
            clr_req = (k == 4);
            exp(0, 16'h0, 0, "t4_clr_byp");
            if (k < 7) exp(1, 16'h0107, 1, "t4_unswept");
            else       exp(1, 16'h0, 0, "t4_last_byp");
            exp(2, 16'h0, (k < 7), "t4_busy");
            tick();
        end
        wr_en = 0; clr_req = 0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
            exp(0, 16'h0, 0, "t4_post_a"); exp(1, 16'h0, 0, "t4_post_b");
            exp(2, 16'h0, 0, "t4_idle");
            tick();
        end

        // 5: reset in mid-sweep
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = 16'h0200 + 16'(i);
            tick();
        end
        wr_en = 0;
        clr_req = 1;
        exp(2, 16'h0, 1, "t5_busy");
        tick();
        clr_req = 0;
        rd_addr_a = 3'd6; rd_addr_b = 3'd6;
        exp(0, 16'h0206, 1, "t5_unswept"); exp(2, 16'h0, 1, "t5_busy");
        tick();
        exp(2, 16'h0, 1, "t5_busy");
        tick();
        rst_n = 0;
        exp(2, 16'h0, 0, "t5_rst_busy"); exp(0, 16'h0, 0, "t5_rst_a"); exp(1, 16'h0, 0, "t5_rst_b");
        tick();
        rst_n = 1;
        wr_en = 1; wr_addr = 3'd6; wr_data = 16'hAAAA; rd_addr_a = 3'd6; rd_addr_b = 3'd5;
        exp(0, 16'hAAAA, 1, "t5_wr_byp"); exp(1, 16'h0, 0, "t5_wiped");
        exp(2, 16'h0, 0, "t5_busy_low");
        tick();
        wr_en = 0;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            exp(0, (i == 6) ? 16'hAAAA : 16'h0, (i == 6), "t5_all_a");
            exp(1, (i == 6) ? 16'hAAAA : 16'h0, (i == 6), "t5_all_b");
            tick();
        end

        // 6: DEPTH=5 instance, out-of-range addresses and 5-cycle sweep
        wr_en5 = 1; wr_addr5 = 3'd6; wr_data5 = 16'h5555; rd_addr_a5 = 3'd6; rd_addr_b5 = 3'd4;
        exp(3, 16'h0, 0, "t6_oor_byp"); exp(4, 16'h0, 0, "t6_empty4");
        tick();
        wr_addr5 = 3'd4; wr_data5 = 16'h4444;
        exp(4, 16'h4444, 1, "t6_byp4");
        tick();
        wr_addr5 = 3'd7; wr_data5 = 16'h7777;
        tick();
        wr_en5 = 0;
        rd_addr_a5 = 3'd6; rd_addr_b5 = 3'd4;
        exp(3, 16'h0, 0, "t6_oor6"); exp(4, 16'h4444, 1, "t6_rd4");
        tick();
        rd_addr_a5 = 3'd7;
        exp(3, 16'h0, 0, "t6_oor7");
        tick();
        clr_req5 = 1;
        exp(5, 16'h0, 1, "t6_busy_start");
        tick();
        clr_req5 = 0;
        for (int k = 0; k < 5; k++) begin
            exp(5, 16'h0, (k < 4), "t6_busy");
            tick();
        end
        rd_addr_a5 = 3'd4;
        exp(3, 16'h0, 0, "t6_cleared4"); exp(5, 16'h0, 0, "t6_idle");
        tick();

        tick(); tick();
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
